// File: rtl/ps2_host_tx_if.sv
// Request/status bundle between a command source and the PS/2 host transmitter.
// The source drives a byte with tx_valid and watches busy and the result pulses.
`timescale 1ns/1ps
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  busy,
        input  tx_done,
        input  tx_error
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output busy,
        output tx_done,
        output tx_error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, 8 data bits LSB first,
// odd parity, stop, then device ACK; open-drain lines via pull-low enables.
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1200,
    parameter int SETUP_CYCLES   = 20,
    parameter int TIMEOUT_CYCLES = 150000
) (
    input  logic             clock,
    input  logic             reset,
    ps2_host_tx_if.slave     tx,
    input  logic             ps2_clk_in,
    input  logic             ps2_data_in,
    output logic             ps2_clk_oe,
    output logic             ps2_data_oe
);

    localparam int M1   = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int MAXC = (M1 > TIMEOUT_CYCLES) ? M1 : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        DATA,
        PARITY,
        STOP,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    byte_q;
    logic          par_q;
    logic          ready_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_prev;
    logic          fall;
    logic          data_s;
    logic          active;
    logic          timeout;

    // Lines idle high, so the synchronisers reset to 1 to avoid a false edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_data_in};
            clk_prev <= clk_sync[1];
        end
    end

    assign fall    = clk_prev & ~clk_sync[1];
    assign data_s  = dat_sync[1];
    assign active  = (state == DATA) || (state == PARITY) || (state == STOP) ||
                     (state == ACK) || (state == WAIT_IDLE);
    assign timeout = active && (cnt == TO_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            byte_q      <= '0;
            par_q       <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (active) begin
                cnt <= fall ? '0 : cnt + CW'(1);
            end
            if (timeout) begin
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                err_q       <= 1'b1;
                busy_q      <= 1'b0;
                cnt         <= '0;
                state       <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        // Ready returns one cycle after the result pulse.
                        if (!ready_q) begin
                            ready_q <= 1'b1;
                        end else if (tx.tx_valid) begin
                            byte_q     <= tx.tx_data;
                            par_q      <= ~^tx.tx_data;
                            ready_q    <= 1'b0;
                            busy_q     <= 1'b1;
                            cnt        <= '0;
                            ps2_clk_oe <= 1'b1;
                            state      <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (cnt == INH_LAST) begin
                            cnt         <= '0;
                            ps2_data_oe <= 1'b1;
                            state       <= START;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    START: begin
                        if (cnt == SET_LAST) begin
                            cnt        <= '0;
                            bit_cnt    <= '0;
                            ps2_clk_oe <= 1'b0;
                            state      <= DATA;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    DATA: begin
                        if (fall) begin
                            ps2_data_oe <= ~byte_q[bit_cnt];
                            bit_cnt     <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= PARITY;
                            end
                        end
                    end
                    PARITY: begin
                        if (fall) begin
                            ps2_data_oe <= ~par_q;
                            state       <= STOP;
                        end
                    end
                    STOP: begin
                        if (fall) begin
                            ps2_data_oe <= 1'b0;
                            state       <= ACK;
                        end
                    end
                    ACK: begin
                        if (fall) begin
                            if (!data_s) begin
                                state <= WAIT_IDLE;
                            end else begin
                                err_q  <= 1'b1;
                                busy_q <= 1'b0;
                                state  <= IDLE;
                            end
                        end
                    end
                    WAIT_IDLE: begin
                        if (clk_sync[1] && data_s) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign tx.tx_ready = ready_q;
    assign tx.busy     = busy_q;
    assign tx.tx_done  = done_q;
    assign tx.tx_error = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks the frame out and ACKs,
// and every frame is compared with one built from the byte and odd parity.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH = 1200;
    localparam int SET = 20;
    localparam int TO  = 5000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic ps2_clk_oe;
    logic ps2_data_oe;
    logic clk_line;
    logic data_line;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_fall = 0;
    int t_err = 0;
    int mon_done = 0;
    int mon_err = 0;
    int mon_both = 0;
    int mon_long = 0;
    int mon_busy = 0;
    int mon_oe = 0;
    logic prev_done = 1'b0;
    logic prev_err = 1'b0;

    ps2_host_tx_if bus();

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .SETUP_CYCLES(SET),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .tx(bus),
        .ps2_clk_in(clk_line),
        .ps2_data_in(data_line),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    // Open-drain wired-AND of host enables and device drive.
    assign clk_line  = dev_clk & ~ps2_clk_oe;
    assign data_line = dev_data & ~ps2_data_oe;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (bus.tx_done) mon_done++;
        if (bus.tx_error) begin
            mon_err++;
            t_err = cyc;
        end
        if (bus.tx_done && bus.tx_error) mon_both++;
        if ((bus.tx_done && prev_done) || (bus.tx_error && prev_err)) mon_long++;
        if ((bus.tx_done || bus.tx_error) && bus.busy) mon_busy++;
        if ((ps2_clk_oe || ps2_data_oe) && !bus.busy) mon_oe++;
        prev_done = bus.tx_done;
        prev_err  = bus.tx_error;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic [9:0] exp_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0), b};
    endfunction

    task automatic start_tx(input logic [7:0] b, input bit hold);
        int w = 0;
        @(negedge clock);
        while (!bus.tx_ready && w < 5000) begin
            @(negedge clock);
            w++;
        end
        chk("ready_before_send", bus.tx_ready, 1);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        @(posedge clock);
        #1;
        chk("busy_after_accept", {bus.busy, bus.tx_ready}, 2'b10);
        if (!hold) bus.tx_valid = 1'b0;
    endtask

    task automatic host_phases();
        int n = 0;
        int m = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < 3 * INH) begin
            n++;
            @(posedge clock);
            #1;
        end
        chk("inhibit_len", n, INH);
        while (ps2_clk_oe && ps2_data_oe && m < 3 * INH) begin
            m++;
            @(posedge clock);
            #1;
        end
        chk("setup_len", m, SET);
        chk("start_bit", {ps2_clk_oe, ps2_data_oe}, 2'b01);
    endtask

    task automatic device(input int nfalls, input int half, input bit ack,
                          output logic [9:0] frame);
        frame = '0;
        for (int k = 1; k <= nfalls; k++) begin
            repeat (half) @(negedge clock);
            dev_clk = 1'b0;
            t_fall  = cyc;
            repeat (half) @(negedge clock);
            if (k <= 10) frame[k-1] = data_line;
            if (k == 11) chk("ack_released", ps2_data_oe, 0);
            dev_clk = 1'b1;
            if (k == 10 && ack) dev_data = 1'b0;
        end
        repeat (half) @(negedge clock);
        dev_data = 1'b1;
    endtask

    task automatic wait_end(input int d0, input int e0, input int limit);
        int w = 0;
        while (mon_done == d0 && mon_err == e0 && w < limit) begin
            @(negedge clock);
            w++;
        end
    endtask

    task automatic check_idle(input string tag);
        @(posedge clock);
        #1;
        chk(tag, {bus.tx_ready, bus.busy, ps2_clk_oe, ps2_data_oe}, 4'b1000);
    endtask

    task automatic full_tx(input logic [7:0] b, input int half, input bit ack);
        logic [9:0] fr;
        int d0;
        int e0;
        start_tx(b, 1'b0);
        host_phases();
        d0 = mon_done;
        e0 = mon_err;
        device(11, half, ack, fr);
        chk("frame", fr, exp_frame(b));
        wait_end(d0, e0, 500);
        chk("done_pulses", mon_done - d0, ack ? 1 : 0);
        chk("error_pulses", mon_err - e0, ack ? 0 : 1);
        check_idle("idle_after_tx");
    endtask

    initial begin
        logic [9:0] fr;
        logic [7:0] b;
        int d0;
        int e0;
        int w;

        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_outputs",
            {bus.tx_ready, bus.busy, bus.tx_done, bus.tx_error, ps2_clk_oe, ps2_data_oe},
            6'b100000);
        reset = 1'b0;

        full_tx(8'hED, 40, 1'b1);
        full_tx(8'h01, 40, 1'b1);
        full_tx(8'h00, 40, 1'b0);

        // Device stalls after four falls.
        b = 8'($urandom);
        start_tx(b, 1'b0);
        host_phases();
        d0 = mon_done;
        e0 = mon_err;
        device(4, 40, 1'b1, fr);
        chk("partial_frame", fr[3:0], b[3:0]);
        wait_end(d0, e0, TO + 200);
        chk("timeout_error", mon_err - e0, 1);
        chk("timeout_no_done", mon_done - d0, 0);
        // Two synchroniser flops plus the edge register before the count restarts.
        chk("timeout_delay", t_err - t_fall, TO + 3);
        check_idle("idle_after_timeout");

        // Reset while bit 3 (a zero) is being driven.
        start_tx(8'hF0, 1'b0);
        host_phases();
        device(4, 40, 1'b1, fr);
        chk("bit3_driven", ps2_data_oe, 1);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("async_release", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        chk("reset_ready", {bus.tx_ready, bus.busy}, 2'b10);
        @(negedge clock);
        reset = 1'b0;
        full_tx(8'hF4, 40, 1'b1);

        // Valid held through a transfer while the byte changes underneath.
        start_tx(8'h3C, 1'b1);
        bus.tx_data = 8'hFF;
        host_phases();
        device(11, 40, 1'b1, fr);
        chk("held_frame", fr, exp_frame(8'h3C));
        w = 0;
        while (!bus.tx_done && w < 500) begin
            @(posedge clock);
            #1;
            w++;
        end
        chk("held_done", {bus.tx_done, bus.busy, bus.tx_ready}, 3'b100);
        @(posedge clock);
        #1;
        chk("ready_after_done", bus.tx_ready, 1);
        @(posedge clock);
        #1;
        chk("back_to_back", {bus.busy, ps2_clk_oe, bus.tx_ready}, 3'b110);
        bus.tx_valid = 1'b0;
        host_phases();
        d0 = mon_done;
        e0 = mon_err;
        device(11, 40, 1'b1, fr);
        chk("second_frame", fr, exp_frame(8'hFF));
        wait_end(d0, e0, 500);
        chk("second_done", mon_done - d0, 1);
        check_idle("idle_after_second");

        for (int i = 0; i < 3; i++) begin
            full_tx(8'($urandom), int'($urandom_range(20, 60)), 1'b1);
        end

        chk("done_and_error_overlap", mon_both, 0);
        chk("pulse_width", mon_long, 0);
        chk("busy_during_pulse", mon_busy, 0);
        chk("oe_outside_busy", mon_oe, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
